// File: rtl/pid_sat_pipe_if.sv
// rtl/pid_sat_pipe_if.sv - sample/limit/result bundle for the saturating PID pipeline
interface pid_sat_pipe_if #(
    parameter int W  = 16,
    parameter int GW = 8
);
    logic                in_valid;
    logic signed [W-1:0] setpoint;
    logic signed [W-1:0] in;
    logic [GW-1:0]       kp;
    logic [GW-1:0]       ki;
    logic [GW-1:0]       kd;
    logic signed [W-1:0] out_min;
    logic signed [W-1:0] out_max;
    logic                hold;
    logic signed [W-1:0] out;
    logic                out_valid;
    logic                sat;

    modport master (
        output in_valid, setpoint, in, kp, ki, kd, out_min, out_max, hold,
        input  out, out_valid, sat
    );

    modport slave (
        input  in_valid, setpoint, in, kp, ki, kd, out_min, out_max, hold,
        output out, out_valid, sat
    );
endinterface

// File: rtl/pid_sat_pipe.sv
// rtl/pid_sat_pipe.sv - 3-stage PID controller with saturating integrator, output clamp and anti-windup
module pid_sat_pipe #(
    parameter int W    = 16,
    parameter int GW   = 8,
    parameter int FRAC = 4,
    parameter int IW   = W + 8
) (
    input  logic          clk,
    input  logic          reset,
    pid_sat_pipe_if.slave bus
);
    localparam int EW   = W + 1;
    localparam int DW   = W + 2;
    localparam int PW   = EW + GW + 1;
    localparam int DPW  = DW + GW + 1;
    localparam int IPW  = IW + GW + 1;
    localparam int MAXW = (IPW > DPW) ? IPW : DPW;
    localparam int SW   = MAXW + 2;

    logic                 v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, ov_q, ov_d;
    logic signed [EW-1:0] e_q, e_d, eprev_q, eprev_d;
    logic signed [DW-1:0] de_q, de_d;
    logic signed [IW-1:0] i_q, i_d;
    logic [GW-1:0]        kp1_q, kp1_d, ki1_q, ki1_d, kd1_q, kd1_d;
    logic signed [PW-1:0]  p_q, p_d;
    logic signed [IPW-1:0] it_q, it_d;
    logic signed [DPW-1:0] d_q, d_d;
    logic signed [SW-1:0]  sum_q, sum_d;
    logic signed [W-1:0]   out_q, out_d;
    logic                  sat_q, sat_d;
    logic signed [1:0]     sat_dir_q, sat_dir_d;

    logic signed [EW-1:0] e_c;
    logic signed [DW-1:0] de_c;
    logic signed [IW:0]   i_sum;
    logic signed [IW-1:0] i_new;
    logic                 skip;
    logic signed [SW-1:0] tot, lim_max, lim_min, out_x;

    always_comb begin
        v1_d      = bus.in_valid;
        e_d       = e_q;
        de_d      = de_q;
        eprev_d   = eprev_q;
        i_d       = i_q;
        kp1_d     = kp1_q;
        ki1_d     = ki1_q;
        kd1_d     = kd1_q;
        v2_d      = v1_q;
        v3_d      = v2_q;
        ov_d      = v3_q;
        out_d     = out_q;
        sat_d     = sat_q;
        sat_dir_d = sat_dir_q;

        e_c   = EW'(bus.setpoint) - EW'(bus.in);
        de_c  = DW'(e_c) - DW'(eprev_q);
        i_sum = {i_q[IW-1], i_q} + (IW+1)'(e_c);
        if (i_sum[IW] != i_sum[IW-1])
            i_new = i_sum[IW] ? {1'b1, {(IW-1){1'b0}}} : {1'b0, {(IW-1){1'b1}}};
        else
            i_new = i_sum[IW-1:0];
        // Anti-windup uses the registered direction only; results landing this edge are not forwarded.
        skip = bus.hold
            || (sat_dir_q == 2'sb01 && !e_c[EW-1] && (e_c != '0))
            || (sat_dir_q == 2'sb11 && e_c[EW-1]);

        if (bus.in_valid) begin
            e_d     = e_c;
            de_d    = de_c;
            eprev_d = e_c;
            kp1_d   = bus.kp;
            ki1_d   = bus.ki;
            kd1_d   = bus.kd;
            if (!skip)
                i_d = i_new;
        end

        // i_q still holds this sample's I_new here: the next sample can only change it at this same edge.
        p_d  = PW'(e_q) * PW'($signed({1'b0, kp1_q}));
        it_d = IPW'(i_q) * IPW'($signed({1'b0, ki1_q}));
        d_d  = DPW'(de_q) * DPW'($signed({1'b0, kd1_q}));

        tot   = SW'(p_q) + SW'(it_q) + SW'(d_q);
        sum_d = tot >>> FRAC;

        lim_max = SW'(bus.out_max);
        lim_min = SW'(bus.out_min);
        if (v3_q) begin
            if (lim_min > lim_max || sum_q < lim_min) begin
                out_d = bus.out_min;
                sat_d = 1'b1;
            end else if (sum_q > lim_max) begin
                out_d = bus.out_max;
                sat_d = 1'b1;
            end else begin
                out_d = sum_q[W-1:0];
                sat_d = 1'b0;
            end
            out_x = SW'(out_d);
            // Direction in which the output was pushed: +1 when clipped down, -1 when clipped up.
            if (sum_q > out_x)
                sat_dir_d = 2'sb01;
            else if (sum_q < out_x)
                sat_dir_d = 2'sb11;
            else
                sat_dir_d = 2'sb00;
        end else begin
            out_x = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            ov_q      <= 1'b0;
            out_q     <= '0;
            sat_q     <= 1'b0;
            i_q       <= '0;
            eprev_q   <= '0;
            sat_dir_q <= 2'sb00;
        end else begin
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            v3_q      <= v3_d;
            ov_q      <= ov_d;
            out_q     <= out_d;
            sat_q     <= sat_d;
            i_q       <= i_d;
            eprev_q   <= eprev_d;
            sat_dir_q <= sat_dir_d;
        end
    end

    always_ff @(posedge clk) begin
        e_q   <= e_d;
        de_q  <= de_d;
        kp1_q <= kp1_d;
        ki1_q <= ki1_d;
        kd1_q <= kd1_d;
        p_q   <= p_d;
        it_q  <= it_d;
        d_q   <= d_d;
        sum_q <= sum_d;
    end

    assign bus.out       = out_q;
    assign bus.sat       = sat_q;
    assign bus.out_valid = ov_q;
endmodule

// File: doc/pid_sat_pipe.md
PID_SAT_PIPE -- requirements
Module: pid_sat_pipe

Interface
REQ-001 Parameters: W, default 16, data width of setpoint, measurement, limits and output; all signed two's complement.
REQ-002 Parameters: GW, default 8, gain width; gains are unsigned.
REQ-003 Parameters: FRAC, default 4, fractional bits of each gain (gain 2^FRAC = 1.0).
REQ-004 Parameters: IW, default W+8, integrator register width, signed.
REQ-005 Port: clk  in  1  rising-edge clock.
REQ-006 Port: reset  in  1  synchronous, active-high reset.
REQ-007 Port: in_valid  in  1  sample strobe; one sample accepted per cycle when high.
REQ-008 Port: setpoint  in  W  target value.
REQ-009 Port: in  in  W  measured process value.
REQ-010 Port: kp, ki, kd  in  GW each  proportional, integral and derivative gains.
REQ-011 Port: out_min, out_max  in  W  output clamp limits.
REQ-012 Port: hold  in  1  freezes integrator accumulation for the accepted sample.
REQ-013 Port: out  out  W  controller output.
REQ-014 Port: out_valid  out  1  one-cycle pulse per result.
REQ-015 Port: sat  out  1  high when out was clipped.

Function
REQ-016 Pipeline: the module SHALL have 3 stages; result for a sample accepted at edge N SHALL appear, with out_valid=1, at edge N+3; full throughput, no stalls.
REQ-017 Stage 1: the module SHALL compute e = setpoint - in in W+1 bits, de = e - e_prev, and I_new; it SHALL capture kp/ki/kd with the sample.
REQ-018 e_prev SHALL update to e only on accepted samples; after reset it is 0, so the first de equals e.
REQ-019 Integrator: I_new = I + e, saturating at the signed IW limits; I updates only on accepted samples.
REQ-020 Integration SHALL be skipped (I_new = I) when hold=1, when sat_dir=+1 and e>0, or when sat_dir=-1 and e<0.
REQ-021 Stage 2: the module SHALL form P = kp*e, Itm = ki*I_new, D = kd*de as exact signed products; gains are zero-extended.
REQ-022 Stage 3: the module SHALL form sum = (P + Itm + D) >>> FRAC; the shift is arithmetic, floor rounding, and intermediate width is sized so no overflow occurs.
REQ-023 Clamp: sum > out_max gives out = out_max and sat=1; sum < out_min gives out = out_min and sat=1; otherwise out = sum[W-1:0] and sat=0.
REQ-024 When out_min > out_max, out SHALL equal out_min and sat=1.
REQ-025 sat_dir SHALL be set to +1, -1 or 0 from the stage-3 clamp of each result, at the edge out_valid asserts.
REQ-026 Samples already in flight SHALL use sat_dir as registered at their stage-1 edge, with no forwarding.
REQ-027 Between results, out and sat SHALL hold their last values; out_valid SHALL be 0.
REQ-028 Limits SHALL be sampled at stage 3, the cycle the result is formed.

Reset
REQ-029 On reset, the following SHALL clear to 0: out, sat, out_valid, I, e_prev, sat_dir, and all pipeline valid bits.
REQ-030 Reset mid-operation SHALL discard in-flight samples, so no out_valid follows until 3 cycles after the next accepted sample.
REQ-031 A sample presented with reset=1 SHALL NOT be accepted.

Verification
REQ-032 Proportional case: kp=16, ki=kd=0, setpoint=165, in=0, out_max=1000, out_min=-1000, single strobe -> out=165 at edge N+3, sat=0, then out_valid=0.
REQ-033 Integral case: ki=16, kp=kd=0, e=10 held with 5 back-to-back strobes -> outputs 10,20,30,40,50 on consecutive cycles.
REQ-034 Derivative case: kd=16 only, e sequence 0,10,10 -> outputs 0,10,0.
REQ-035 Saturation and anti-windup case: ki=16, out_max=100, e=60 streamed -> outputs 60,120->100 (sat=1), I stops growing once sat_dir=+1. Then e=-10 -> I decreases immediately.
REQ-036 Boundary case: out_min=50, out_max=20 -> out=50, sat=1. Hold case: hold=1 with ki=16 -> I unchanged.
REQ-037 Reset case: reset asserted one cycle while 2 samples are in flight -> no out_valid from them, out=0, next sample's de equals its e.
